updown_counter_gen2: RTL
========================

# updown_counter_gen2

Parametrised successor to the 8-bit programmable counter: a WIDTH-bit up/down counter with a programmable limit, synchronous load, an optional clock-enable prescaler, and a small run-control FSM. It supports four counting modes: wrap, saturate, one-shot and hold. The block sits behind the chip-level pin wrapper, which maps `ui_in`/`uio_in` onto the control inputs and drives `uo_out` from `count`. It is the counting core reused by the timer and PWM blocks.

## Interface
Parameters:
- `WIDTH`, 8: counter, limit and load width (≥2)
- `PS_W`, 4: prescaler divider width

Ports:
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `ena`  in  1  global enable; 0 freezes all state except reset
- `load`  in  1  synchronous load strobe
- `load_val`  in  WIDTH  value loaded on `load`
- `start`  in  1  arm/run strobe
- `stop`  in  1  halt strobe
- `dir`  in  1  1 = count up, 0 = count down
- `mode`  in  2  00 wrap, 01 saturate, 10 one-shot, 11 hold
- `limit`  in  WIDTH  upper bound of the count range
- `ps_div`  in  PS_W  step every `ps_div`+1 RUN cycles
- `count`  out  WIDTH  current count
- `tc`  out  1  terminal-count pulse, registered
- `running`  out  1  FSM in RUN
- `done`  out  1  FSM in DONE

## Operation
- **FSM states:** IDLE, RUN, DONE.
- **Reset values:** state IDLE, `count`=0, prescaler=0, `tc`=0, `running`=0, `done`=0.
- **Per-cycle priority (ena=1):** `load` > `stop` > `start` > step.
  - `load`: `count`←`load_val`, prescaler←0. State is kept, except DONE→IDLE.
  - `stop`: →IDLE, `count` held, prescaler←0.
  - `start`: from IDLE or DONE →RUN, prescaler←0. Ignored in RUN.
- **ena=0:** nothing updates (`count`, state, prescaler) and `tc` is forced to 0.
- **Tick:** occurs in RUN when prescaler==`ps_div`; the prescaler then returns to 0. Otherwise the prescaler increments in RUN and stays at 0 outside RUN.
- **Terminal condition:**
  - up: `count` ≥ `limit`
  - down: `count` == 0
- **Non-terminal tick:** `count` ±1.
- **Terminal tick, by mode:**
  - wrap: `count`←0 (up) or `limit` (down); stays in RUN.
  - saturate: `count` held; →DONE.
  - one-shot: `count`←0 (up) or `limit` (down); →IDLE.
  - hold: `count` never changes; ticks occur but never produce `tc`.
- **tc:** high for exactly one cycle following every terminal tick in modes 00/01/10.
- **Mid-run changes:** `dir`, `mode`, `limit` and `ps_div` are sampled live and take effect on the next tick or compare.
- **Out-of-range load:** a loaded value above `limit` when counting up is terminal on the next tick. When counting down it counts through normally.
- **Arithmetic:** all arithmetic is modulo 2^WIDTH; no other overflow is possible.

## Timing
- `start` sampled at edge k → `running`=1 after edge k.
- First step at edge k+1+`ps_div`; then every `ps_div`+1 edges.
- `count`, `running`, `done` and `tc` are all registered and update on the same edge. `tc` is not combinational from the inputs.
- **Reset mid-operation:** asynchronous assertion clears all outputs immediately. Deassertion must be synchronised externally; the first active edge after release behaves as from IDLE.
- **Simultaneous events:**
  - `load`+`start` in IDLE: load wins, state stays IDLE.
  - `load` during a tick: load wins; no `tc`.
  - `stop`+terminal tick: stop wins; no `tc`.

## Configuration
- `UPDOWN_COUNTER_PRESCALE_EN` defined: the prescaler register and compare are built as described above.
- Not defined: the prescaler logic is removed, `ps_div` is ignored (port kept), and every RUN cycle is a tick.

## Test plan
- **Reset/wrap:** reset, mode 00, dir 1, limit 5, ps_div 0, start → count 1,2,3,4,5,0. `tc` high one cycle with count=0; `running` stays 1.
- **Down/saturate:** load 3, mode 01, dir 0, start → 2,1,0, then next tick count 0 held, `tc` 1 cycle, `done`=1. A subsequent `start` resumes RUN but terminates again with `tc`.
- **One-shot/prescale:** mode 10, dir 1, limit 2, ps_div 3 → steps every 4 cycles 1,2, then count 0, `tc`, `running`=0; total 12 cycles from start to `tc` (with macro). Without macro: 3 cycles.
- **Priority:** in RUN assert `load`(val 7)+`stop` together → count 7, state RUN, prescaler 0. Next cycle `stop` alone → IDLE, count 7 held.
- **ena gating:** mid-run, hold `ena`=0 for 5 cycles → count, prescaler and state frozen, `tc`=0. Resume continues from the exact prior phase.
- **Async reset mid-run:** pulse `rst_n` low between edges → count 0, `running` 0, `tc` 0 before the next edge. Mode 11 run for 20 cycles → count unchanged, `tc` never asserted.

Source files
------------

// File: rtl/updown_counter_gen2.sv
// rtl/updown_counter_gen2.sv - WIDTH-bit up/down counter with limit, load, prescaler and run FSM
// Optional prescaler built when UPDOWN_COUNTER_PRESCALE_EN is defined.
module updown_counter_gen2 #(
    parameter int WIDTH = 8,
    parameter int PS_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             stop,
    input  logic             dir,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [PS_W-1:0]  ps_div,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

    localparam logic [1:0] M_WRAP    = 2'b00;
    localparam logic [1:0] M_SAT     = 2'b01;
    localparam logic [1:0] M_ONESHOT = 2'b10;
    localparam logic [1:0] M_HOLD    = 2'b11;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             tick;
    logic             terminal;

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    logic [PS_W-1:0] ps_q, ps_d;
    assign tick = (state_q == S_RUN) && (ps_q == ps_div);
`else
    logic ps_div_unused;
    assign ps_div_unused = ^ps_div;
    assign tick = (state_q == S_RUN);
`endif

    // Up counting treats anything at or past the limit as terminal so an
    // out-of-range load cannot run away through the top of the range.
    assign terminal = dir ? (count_q >= limit) : (count_q == '0);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
`ifdef UPDOWN_COUNTER_PRESCALE_EN
        ps_d    = '0;
`endif
        if (load) begin
            count_d = load_val;
            if (state_q == S_DONE) begin
                state_d = S_IDLE;
            end
        end else if (stop) begin
            state_d = S_IDLE;
        end else if (start && (state_q != S_RUN)) begin
            state_d = S_RUN;
        end else if (state_q == S_RUN) begin
`ifdef UPDOWN_COUNTER_PRESCALE_EN
            ps_d = tick ? '0 : ps_q + 1'b1;
`endif
            if (tick && (mode != M_HOLD)) begin
                if (terminal) begin
                    tc_d = 1'b1;
                    case (mode)
                        M_WRAP: begin
                            count_d = dir ? '0 : limit;
                        end
                        M_SAT: begin
                            state_d = S_DONE;
                        end
                        M_ONESHOT: begin
                            count_d = dir ? '0 : limit;
                            state_d = S_IDLE;
                        end
                        default: begin
                            count_d = count_q;
                        end
                    endcase
                end else begin
                    count_d = dir ? count_q + 1'b1 : count_q - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else if (ena) begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end else begin
            tc_q    <= 1'b0;
        end
    end

`ifdef UPDOWN_COUNTER_PRESCALE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ps_q <= '0;
        end else if (ena) begin
            ps_q <= ps_d;
        end
    end
`endif

    assign count   = count_q;
    assign tc      = tc_q;
    assign running = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);

endmodule
